// File: rtl/mme_pkg.sv
// mme_pkg
//   Shared constants for the modular-exponentiation sequencer (mme_control)
//   and the sequential Montgomery multiplier it drives.
//   - N_DEF / EXP_W_DEF : default operand and exponent widths (must match the MMM unit)
//   - ST_*              : 3-bit FSM state encoding used by mme_control
//   - SEL_*             : operand-select codes for the MMM operand registers
//   Build option MME_FROM_MONT_EN (see mme_control) uses ST_CONV_ISS/ST_CONV_WAIT/SEL_CONV.
package mme_pkg;

    localparam int N_DEF     = 32;
    localparam int EXP_W_DEF = 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SQ_ISS    = 3'd1;
    localparam logic [2:0] ST_SQ_WAIT   = 3'd2;
    localparam logic [2:0] ST_MUL_ISS   = 3'd3;
    localparam logic [2:0] ST_MUL_WAIT  = 3'd4;
    localparam logic [2:0] ST_CONV_ISS  = 3'd5;
    localparam logic [2:0] ST_CONV_WAIT = 3'd6;
    localparam logic [2:0] ST_FIN       = 3'd7;

    localparam logic [1:0] SEL_SQ   = 2'd0;   // A = B = acc
    localparam logic [1:0] SEL_MUL  = 2'd1;   // A = acc, B = base
    localparam logic [1:0] SEL_CONV = 2'd2;   // A = acc, B = 1

endpackage

// File: rtl/mme_if.sv
// mme_if
//   Handshake/operand bundle between the MME sequencer and the MMM unit.
//   mmm_start : 1-cycle launch pulse (sequencer -> MMM)
//   mmm_a/b   : operands, stable from the launch cycle until mmm_ready
//   mmm_res   : product, valid in the mmm_ready cycle (MMM -> sequencer)
//   mmm_ready : 1-cycle completion pulse
//   modport master = sequencer side, modport slave = MMM side.
interface mme_if #(
    parameter int N = 32
);
    logic         mmm_start;
    logic [N-1:0] mmm_a;
    logic [N-1:0] mmm_b;
    logic [N-1:0] mmm_res;
    logic         mmm_ready;

    modport master (
        output mmm_start, mmm_a, mmm_b,
        input  mmm_res, mmm_ready
    );

    modport slave (
        input  mmm_start, mmm_a, mmm_b,
        output mmm_res, mmm_ready
    );
endinterface

// File: rtl/mme_exp_sreg.sv
// mme_exp_sreg
//   Exponent register and bit-index down-counter for the square-and-multiply walk.
//   clk, rn  : clock, async active-low reset
//   load     : capture e_in and set index to EXP_W-1
//   dec      : step the index down by one
//   e_in     : exponent to capture
//   bit_cur  : exponent bit at the current index
//   last     : index has reached zero (terminal count)
module mme_exp_sreg
    import mme_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rn,
    input  logic             load,
    input  logic             dec,
    input  logic [EXP_W-1:0] e_in,
    output logic             bit_cur,
    output logic             last
);
    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    logic [EXP_W-1:0] e_q;
    logic [IW-1:0]    idx;

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            e_q <= '0;
            idx <= '0;
        end else if (load) begin
            e_q <= e_in;
            idx <= IW'(EXP_W - 1);
        end else if (dec) begin
            idx <= idx - IW'(1);
        end
    end

    assign bit_cur = e_q[idx];
    assign last    = (idx == '0);
endmodule

// File: rtl/mme_control.sv
// mme_control
//   Left-to-right square-and-multiply sequencer for modular exponentiation,
//   driving a sequential Montgomery multiplier through mme_if.master.
//   clk, rn           : clock, async active-low reset (shared with the MMM)
//   start             : request pulse, ignored while busy
//   e, x_mont, one_mont : exponent, base (Montgomery form), R mod M; captured on accepted start
//   mmm               : MMM launch/operand/result handshake
//   busy              : operation in progress (cycle after accepted start .. before done)
//   done              : 1-cycle completion pulse; result valid from here to the next start
//   result            : final accumulator
//   Build option MME_FROM_MONT_EN: append MMM(acc, 1) so result leaves the Montgomery domain.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   IDLE      | waiting for start
//   SQ_ISS    | launch acc*acc
//   SQ_WAIT   | wait for square result
//   MUL_ISS   | launch acc*x (exponent bit set)
//   MUL_WAIT  | wait for multiply result
//   CONV_ISS  | launch acc*1 (MME_FROM_MONT_EN only)
//   CONV_WAIT | wait for conversion result (MME_FROM_MONT_EN only)
//   FIN       | done pulse, return to IDLE
module mme_control
    import mme_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rn,
    input  logic             start,
    input  logic [EXP_W-1:0] e,
    input  logic [N-1:0]     x_mont,
    input  logic [N-1:0]     one_mont,
    mme_if.master            mmm,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     result
);
`ifdef MME_FROM_MONT_EN
    localparam logic [2:0] ST_END = ST_CONV_ISS;
`else
    localparam logic [2:0] ST_END = ST_FIN;
`endif

    logic [2:0]   state, state_nx;
    logic [N-1:0] acc, acc_nx;
    logic [N-1:0] x_reg;
    logic [N-1:0] a_q, b_q;
    logic [N-1:0] result_q;
    logic         exp_load, exp_dec, exp_bit, exp_last;
    logic         op_load;
    logic [1:0]   op_sel;

    mme_exp_sreg #(.EXP_W(EXP_W)) u_exp (
        .clk     (clk),
        .rn      (rn),
        .load    (exp_load),
        .dec     (exp_dec),
        .e_in    (e),
        .bit_cur (exp_bit),
        .last    (exp_last)
    );

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        exp_load = 1'b0;
        exp_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_SQ_ISS;
                    acc_nx   = one_mont;
                    exp_load = 1'b1;
                end
            end
            ST_SQ_ISS: state_nx = ST_SQ_WAIT;
            ST_SQ_WAIT: begin
                if (mmm.mmm_ready) begin
                    acc_nx = mmm.mmm_res;
                    if (exp_bit) begin
                        state_nx = ST_MUL_ISS;
                    end else if (exp_last) begin
                        state_nx = ST_END;
                    end else begin
                        exp_dec  = 1'b1;
                        state_nx = ST_SQ_ISS;
                    end
                end
            end
            ST_MUL_ISS: state_nx = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (mmm.mmm_ready) begin
                    acc_nx = mmm.mmm_res;
                    if (exp_last) begin
                        state_nx = ST_END;
                    end else begin
                        exp_dec  = 1'b1;
                        state_nx = ST_SQ_ISS;
                    end
                end
            end
`ifdef MME_FROM_MONT_EN
            ST_CONV_ISS: state_nx = ST_CONV_WAIT;
            ST_CONV_WAIT: begin
                if (mmm.mmm_ready) begin
                    acc_nx   = mmm.mmm_res;
                    state_nx = ST_FIN;
                end
            end
`endif
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        mmm.mmm_start = (state == ST_SQ_ISS) || (state == ST_MUL_ISS) || (state == ST_CONV_ISS);
        busy          = (state != ST_IDLE) && (state != ST_FIN);
        done          = (state == ST_FIN);
    end

    // Operand registers are loaded on entry to an issue state so they are
    // already valid in the mmm_start cycle and hold until the next issue.
    always_comb begin
        op_load = 1'b1;
        op_sel  = SEL_SQ;
        case (state_nx)
            ST_SQ_ISS:   op_sel = SEL_SQ;
            ST_MUL_ISS:  op_sel = SEL_MUL;
            ST_CONV_ISS: op_sel = SEL_CONV;
            default:     op_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            acc      <= '0;
            x_reg    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            acc <= acc_nx;
            if (state == ST_IDLE && start) x_reg <= x_mont;
            if (op_load) begin
                a_q <= acc_nx;
                case (op_sel)
                    SEL_MUL:  b_q <= x_reg;
                    SEL_CONV: b_q <= N'(1);
                    default:  b_q <= acc_nx;
                endcase
            end
            // Load on entry to FIN so result is already valid with done.
            if (state_nx == ST_FIN) result_q <= acc_nx;
        end
    end

    assign mmm.mmm_a = a_q;
    assign mmm.mmm_b = b_q;
    assign result    = result_q;
endmodule

// File: tb/tb_mme_control.sv
// tb_mme_control
//   Self-checking bench for mme_control with N=8, EXP_W=8, modulus 13 (R = 256).
//   A behavioural MMM (fixed latency 9) answers launches; expected results come
//   from plain modular arithmetic on the base recovered from Montgomery form.
//   Honours MME_FROM_MONT_EN the same way as the design.
module tb_mme_control;
    localparam int N     = 8;
    localparam int EXP_W = 8;
    localparam int MODV  = 13;
    localparam int RMOD  = 9;    // 256 mod 13
    localparam int RINV  = 3;    // 9*3 = 27 = 1 mod 13
    localparam int LAT   = 9;

    logic         clk    = 1'b0;
    logic         rn     = 1'b0;
    logic         start  = 1'b0;
    logic [7:0]   e_in   = 8'd0;
    logic [7:0]   x_in   = 8'd0;
    logic [7:0]   one_in = 8'd0;
    logic         busy, done;
    logic [7:0]   result;

    mme_if #(.N(N)) mif ();

    mme_control #(.N(N), .EXP_W(EXP_W)) dut (
        .clk      (clk),
        .rn       (rn),
        .start    (start),
        .e        (e_in),
        .x_mont   (x_in),
        .one_mont (one_in),
        .mmm      (mif),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Behavioural MMM: result = a*b*R^-1 mod M, ready LAT cycles after launch.
    int         cnt = 0;
    int         launches = 0;
    int         spur_idle_req = 0;
    int         spur_idle_ack = 0;
    logic       spur_iss = 1'b0;
    logic [7:0] a_l = 8'd0, b_l = 8'd0;

    always @(negedge clk) begin
        if (!rn) begin
            cnt           = 0;
            mif.mmm_ready = 1'b0;
            mif.mmm_res   = 8'd0;
        end else begin
            mif.mmm_ready = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    chk("a_stable", 32'(mif.mmm_a), 32'(a_l));
                    chk("b_stable", 32'(mif.mmm_b), 32'(b_l));
                    mif.mmm_ready = 1'b1;
                    mif.mmm_res   = 8'((int'(a_l) * int'(b_l) * RINV) % MODV);
                end
            end else if (spur_idle_req != spur_idle_ack && !busy) begin
                spur_idle_ack++;
                mif.mmm_ready = 1'b1;
                mif.mmm_res   = 8'hAA;
            end
            if (mif.mmm_start) begin
                cnt = LAT;
                a_l = mif.mmm_a;
                b_l = mif.mmm_b;
                launches++;
                if (spur_iss) begin
                    mif.mmm_ready = 1'b1;
                    mif.mmm_res   = 8'h5A;
                end
            end
        end
    end

    int done_cnt = 0;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic int powmod(input int b, input int ex);
        int r = 1;
        for (int k = 0; k < ex; k++) r = (r * b) % MODV;
        return r;
    endfunction

    task automatic run_op(input logic [7:0] ev, input logic [7:0] xv,
                          input logic inject, input logic [7:0] ev2, input logic spur);
        int         l0, d0, c0, budget, exp_l, xn;
        logic [7:0] exp_r;
        xn = (int'(xv) * RINV) % MODV;
`ifdef MME_FROM_MONT_EN
        exp_r = 8'(powmod(xn, int'(ev)));
        exp_l = EXP_W + $countones(ev) + 1;
`else
        exp_r = 8'((powmod(xn, int'(ev)) * RMOD) % MODV);
        exp_l = EXP_W + $countones(ev);
`endif
        spur_iss = spur;
        @(negedge clk);
        start  = 1'b1;
        e_in   = ev;
        x_in   = xv;
        one_in = 8'(RMOD);
        l0 = launches;
        d0 = done_cnt;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_hi", 32'(busy), 32'd1);
        if (inject) begin
            repeat (25) @(negedge clk);
            start = 1'b1;
            e_in  = ev2;
            x_in  = xv + 8'd1;
            @(negedge clk);
            start = 1'b0;
        end
        budget = 0;
        while (done !== 1'b1 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (done !== 1'b1) begin
            chk("done_timeout", 32'(budget), 32'd0);
        end else begin
            chk("result", 32'(result), 32'(exp_r));
            chk("launches", 32'(launches - l0), 32'(exp_l));
            chk("latency", 32'(cyc - c0), 32'(exp_l * (LAT + 1) + 1));
            @(negedge clk);
            #1;
            chk("done_pulse", 32'(done), 32'd0);
            chk("busy_after", 32'(busy), 32'd0);
            chk("done_count", 32'(done_cnt - d0), 32'd1);
            chk("result_hold", 32'(result), 32'(exp_r));
        end
        spur_iss = 1'b0;
    endtask

    task automatic reset_mid_mul();
        int l0, d0, budget;
        @(negedge clk);
        start  = 1'b1;
        e_in   = 8'h80;
        x_in   = 8'd7;
        one_in = 8'(RMOD);
        @(negedge clk);
        start = 1'b0;
        l0 = launches;
        d0 = done_cnt;
        budget = 0;
        while (launches - l0 < 2 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("reach_mul", 32'(launches - l0), 32'd2);
        repeat (3) @(negedge clk);
        #2 rn = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start", 32'(mif.mmm_start), 32'd0);
        chk("rst_a", 32'(mif.mmm_a), 32'd0);
        chk("rst_b", 32'(mif.mmm_b), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        repeat (4) @(negedge clk);
        rn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_start", 32'(mif.mmm_start), 32'd0);
        chk("init_a", 32'(mif.mmm_a), 32'd0);
        chk("init_b", 32'(mif.mmm_b), 32'd0);
        chk("init_result", 32'(result), 32'd0);
        #20;
        @(negedge clk);
        rn = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h00, 8'd4, 1'b0, 8'h00, 1'b0);
        run_op(8'h01, 8'd6, 1'b0, 8'h00, 1'b0);   // X = 5
        run_op(8'hFF, 8'd5, 1'b0, 8'h00, 1'b0);   // X = 2
        run_op(8'hA5, 8'd7, 1'b1, 8'h3C, 1'b0);

        spur_idle_req++;
        repeat (3) @(negedge clk);
        run_op(8'h96, 8'd11, 1'b0, 8'h00, 1'b1);

        reset_mid_mul();
        run_op(8'h80, 8'd7, 1'b0, 8'h00, 1'b0);

        for (int k = 0; k < 8; k++) begin
            logic [7:0] er, xr, er2;
            logic       inj, sp;
            er  = 8'($urandom_range(0, 255));
            xr  = 8'($urandom_range(0, MODV - 1));
            er2 = 8'($urandom_range(0, 255));
            inj = 1'($urandom_range(0, 1));
            sp  = 1'($urandom_range(0, 1));
            if (sp) begin
                spur_idle_req++;
                repeat (2) @(negedge clk);
            end
            run_op(er, xr, inj, er2, sp);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
